// File: rtl/ldst_qid_alloc_if.sv
// Dispatch/retire handshake between alloc and the LDQ/STQ ID allocator.
// LDST_QID_OCC_EN adds the occupancy outputs to the bundle.
package ldst_qid_pkg;
  typedef struct packed {
    logic valid;
  } t_nuke_pkt;
endpackage

interface ldst_qid_alloc_if #(
  parameter int LDQ_DEPTH = 16,
  parameter int STQ_DEPTH = 16
);
  localparam int LDQ_IDW = $clog2(LDQ_DEPTH) + 1;
  localparam int STQ_IDW = $clog2(STQ_DEPTH) + 1;

  ldst_qid_pkg::t_nuke_pkt nuke_rb1;
  logic               disp_valid_rs0;
  logic               disp_is_ld_rs0;
  logic               disp_is_st_rs0;
  logic               ldq_retire;
  logic               stq_retire;
  logic               stq_drain;
  logic [LDQ_IDW-1:0] ldqid_alloc_rs0;
  logic [STQ_IDW-1:0] stqid_alloc_rs0;
  logic               ldq_stall_rs0;
  logic               stq_stall_rs0;
`ifdef LDST_QID_OCC_EN
  logic [LDQ_IDW-1:0] ldq_occ;
  logic [STQ_IDW-1:0] stq_occ;
  logic [STQ_IDW-1:0] stq_senior_cnt;

  modport master (
    output nuke_rb1, disp_valid_rs0, disp_is_ld_rs0, disp_is_st_rs0,
           ldq_retire, stq_retire, stq_drain,
    input  ldqid_alloc_rs0, stqid_alloc_rs0, ldq_stall_rs0, stq_stall_rs0,
           ldq_occ, stq_occ, stq_senior_cnt
  );
  modport slave (
    input  nuke_rb1, disp_valid_rs0, disp_is_ld_rs0, disp_is_st_rs0,
           ldq_retire, stq_retire, stq_drain,
    output ldqid_alloc_rs0, stqid_alloc_rs0, ldq_stall_rs0, stq_stall_rs0,
           ldq_occ, stq_occ, stq_senior_cnt
  );
`else
  modport master (
    output nuke_rb1, disp_valid_rs0, disp_is_ld_rs0, disp_is_st_rs0,
           ldq_retire, stq_retire, stq_drain,
    input  ldqid_alloc_rs0, stqid_alloc_rs0, ldq_stall_rs0, stq_stall_rs0
  );
  modport slave (
    input  nuke_rb1, disp_valid_rs0, disp_is_ld_rs0, disp_is_st_rs0,
           ldq_retire, stq_retire, stq_drain,
    output ldqid_alloc_rs0, stqid_alloc_rs0, ldq_stall_rs0, stq_stall_rs0
  );
`endif
endinterface

// File: rtl/ldst_qid_alloc.sv
// LDQ/STQ entry-ID allocator at the rs0 dispatch boundary.
// IDs carry an MSB wrap bit; STQ keeps head (drain), cmt (retire) and tail.
// Optional: LDST_QID_OCC_EN adds registered occupancy and senior-store count.
module ldst_qid_alloc #(
  parameter int LDQ_DEPTH = 16,
  parameter int STQ_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  ldst_qid_alloc_if.slave  bus
);
  localparam int LDQ_IDW = $clog2(LDQ_DEPTH) + 1;
  localparam int STQ_IDW = $clog2(STQ_DEPTH) + 1;

  logic [LDQ_IDW-1:0] ldq_head, ldq_tail;
  logic [STQ_IDW-1:0] stq_head, stq_cmt, stq_tail;

  logic [LDQ_IDW-1:0] ldq_cnt, ldq_free, ldq_head_nxt, ldq_tail_nxt;
  logic [STQ_IDW-1:0] stq_cnt, stq_free, stq_head_nxt, stq_cmt_nxt, stq_tail_nxt;
  logic ldq_alloc, stq_alloc, ldq_full, stq_full, nuke;
  logic ldq_alloc_ok, stq_alloc_ok, ldq_ret_ok, stq_ret_ok, stq_drn_ok;

  // Occupancy, legality gating and next-pointer computation
  always_comb begin
    nuke      = bus.nuke_rb1.valid;
    ldq_alloc = bus.disp_valid_rs0 & bus.disp_is_ld_rs0;
    stq_alloc = bus.disp_valid_rs0 & bus.disp_is_st_rs0;
    ldq_cnt   = ldq_tail - ldq_head;
    stq_cnt   = stq_tail - stq_head;
    ldq_full  = (ldq_cnt == LDQ_IDW'(LDQ_DEPTH));
    stq_full  = (stq_cnt == STQ_IDW'(STQ_DEPTH));
    ldq_free  = LDQ_IDW'(LDQ_DEPTH) - ldq_cnt;
    stq_free  = STQ_IDW'(STQ_DEPTH) - stq_cnt;

    // Illegal requests leave the pointers untouched
    ldq_alloc_ok = ldq_alloc & ~ldq_full & ~nuke;
    stq_alloc_ok = stq_alloc & ~stq_full & ~nuke;
    ldq_ret_ok   = bus.ldq_retire & (ldq_cnt != '0);
    stq_ret_ok   = bus.stq_retire & (stq_cmt != stq_tail);
    stq_drn_ok   = bus.stq_drain & (stq_head != stq_cmt);

    ldq_head_nxt = ldq_head + LDQ_IDW'(ldq_ret_ok);
    stq_cmt_nxt  = stq_cmt + STQ_IDW'(stq_ret_ok);
    stq_head_nxt = stq_head + STQ_IDW'(stq_drn_ok);
    // Nuke squashes everything younger than the retire point (post-retire)
    ldq_tail_nxt = nuke ? ldq_head_nxt : ldq_tail + LDQ_IDW'(ldq_alloc_ok);
    stq_tail_nxt = nuke ? stq_cmt_nxt  : stq_tail + STQ_IDW'(stq_alloc_ok);
  end

  // Pointer state
  always_ff @(posedge clk) begin
    if (reset) begin
      ldq_head <= '0;
      ldq_tail <= '0;
      stq_head <= '0;
      stq_cmt  <= '0;
      stq_tail <= '0;
    end else begin
      ldq_head <= ldq_head_nxt;
      ldq_tail <= ldq_tail_nxt;
      stq_head <= stq_head_nxt;
      stq_cmt  <= stq_cmt_nxt;
      stq_tail <= stq_tail_nxt;
    end
  end

  // ID is the current tail; stall reserves a slot for the uop already in flight
  // ra0->rs0 and ignores same-cycle frees.
  always_comb begin
    bus.ldqid_alloc_rs0 = ldq_tail;
    bus.stqid_alloc_rs0 = stq_tail;
    bus.ldq_stall_rs0   = (ldq_free <= LDQ_IDW'(ldq_alloc));
    bus.stq_stall_rs0   = (stq_free <= STQ_IDW'(stq_alloc));
  end

`ifdef LDST_QID_OCC_EN
  // Occupancy reported one cycle late
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ldq_occ <= '0;
      bus.stq_occ <= '0;
    end else begin
      bus.ldq_occ <= ldq_cnt;
      bus.stq_occ <= stq_cnt;
    end
  end

  // Retired stores still waiting to drain
  always_comb bus.stq_senior_cnt = stq_cmt - stq_head;
`endif

  a_ld_st_excl: assert property (@(posedge clk) disable iff (reset)
    !(bus.disp_valid_rs0 & bus.disp_is_ld_rs0 & bus.disp_is_st_rs0));
  a_ldq_ovf: assert property (@(posedge clk) disable iff (reset) !(ldq_alloc & ldq_full & ~nuke));
  a_stq_ovf: assert property (@(posedge clk) disable iff (reset) !(stq_alloc & stq_full & ~nuke));
  a_ldq_unf: assert property (@(posedge clk) disable iff (reset) !(bus.ldq_retire & (ldq_cnt == '0)));
  a_stq_ret: assert property (@(posedge clk) disable iff (reset) !(bus.stq_retire & (stq_cmt == stq_tail)));
  a_stq_drn: assert property (@(posedge clk) disable iff (reset) !(bus.stq_drain & (stq_head == stq_cmt)));
  a_stq_ord: assert property (@(posedge clk) disable iff (reset)
    ((stq_cmt - stq_head) <= stq_cnt) && (stq_cnt <= STQ_IDW'(STQ_DEPTH)));

endmodule

// File: tb/tb_ldst_qid_alloc.sv
// Directed bench for ldst_qid_alloc: alloc IDs, stall, wrap, nuke rollback, drain.
module tb_ldst_qid_alloc;
  logic clk = 1'b0;
  logic reset;
  int   n_run  = 0;
  int   n_fail = 0;

  ldst_qid_alloc_if #(.LDQ_DEPTH(16), .STQ_DEPTH(16)) bus ();
  ldst_qid_alloc #(.LDQ_DEPTH(16), .STQ_DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.nuke_rb1.valid  = 1'b0;
    bus.disp_valid_rs0  = 1'b0;
    bus.disp_is_ld_rs0  = 1'b0;
    bus.disp_is_st_rs0  = 1'b0;
    bus.ldq_retire      = 1'b0;
    bus.stq_retire      = 1'b0;
    bus.stq_drain       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld();
    bus.disp_valid_rs0 = 1'b1;
    bus.disp_is_ld_rs0 = 1'b1;
  endtask

  task automatic st();
    bus.disp_valid_rs0 = 1'b1;
    bus.disp_is_st_rs0 = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_ldqid", 32'(bus.ldqid_alloc_rs0), 0);
    chk("rst_stqid", 32'(bus.stqid_alloc_rs0), 0);
    chk("rst_ldstall", 32'(bus.ldq_stall_rs0), 0);
    chk("rst_ststall", 32'(bus.stq_stall_rs0), 0);

    // 1: three loads get IDs 0,1,2
    for (int i = 0; i < 3; i++) begin
      ld(); #1;
      chk("t1_ldqid", 32'(bus.ldqid_alloc_rs0), 32'(i));
      chk("t1_stall", 32'(bus.ldq_stall_rs0), 0);
      tick(); idle();
    end
    #1;
    chk("t1_tail", 32'(bus.ldqid_alloc_rs0), 3);

    // 2: fill to 15, load at rs0 stalls same cycle; retire drops it next cycle
    for (int i = 0; i < 12; i++) begin ld(); tick(); idle(); end
    #1;
    chk("t2_tail15", 32'(bus.ldqid_alloc_rs0), 15);
    chk("t2_nostall", 32'(bus.ldq_stall_rs0), 0);
    ld(); #1;
    chk("t2_stall_ld", 32'(bus.ldq_stall_rs0), 1);
    tick(); idle();
    bus.ldq_retire = 1'b1; #1;
    chk("t2_stall_full", 32'(bus.ldq_stall_rs0), 1);
    tick(); idle(); #1;
    chk("t2_stall_drop", 32'(bus.ldq_stall_rs0), 0);

    // reset mid-operation overrides activity
    reset = 1'b1; ld(); bus.ldq_retire = 1'b1;
    tick(); reset = 1'b0; idle(); #1;
    chk("rst_mid_tail", 32'(dut.ldq_tail), 0);
    chk("rst_mid_head", 32'(dut.ldq_head), 0);

    // 3: 20 loads with retires interleaved, ID wraps to 16 (wrap bit set, idx 0)
    for (int i = 0; i < 20; i++) begin
      ld(); bus.ldq_retire = (i > 0); #1;
      chk("t3_ldqid", 32'(bus.ldqid_alloc_rs0), 32'(i));
      chk("t3_stall", 32'(bus.ldq_stall_rs0), 0);
      tick(); idle();
    end
    #1;
    chk("t3_tail", 32'(dut.ldq_tail), 20);
    chk("t3_head", 32'(dut.ldq_head), 19);

    // 4: stores 0..4, retire 2, nuke rolls tail back to cmt, drain 2 empties
    do_reset();
    for (int i = 0; i < 5; i++) begin
      st(); #1;
      chk("t4_stqid", 32'(bus.stqid_alloc_rs0), 32'(i));
      tick(); idle();
    end
    bus.stq_retire = 1'b1;
    repeat (2) tick();
    idle();
    bus.nuke_rb1.valid = 1'b1;
    tick(); idle(); #1;
    chk("t4_nuke_stqid", 32'(bus.stqid_alloc_rs0), 2);
    chk("t4_cmt", 32'(dut.stq_cmt), 2);
    bus.stq_drain = 1'b1;
    repeat (2) tick();
    idle(); #1;
    chk("t4_head", 32'(dut.stq_head), 2);
    chk("t4_tail", 32'(dut.stq_tail), 2);
    chk("t4_ststall", 32'(bus.stq_stall_rs0), 0);

    // 5: nuke + load alloc + retire at head=0,tail=4 -> head=tail=1
    do_reset();
    for (int i = 0; i < 4; i++) begin ld(); tick(); idle(); end
    ld(); bus.ldq_retire = 1'b1; bus.nuke_rb1.valid = 1'b1;
    tick(); idle(); #1;
    chk("t5_head", 32'(dut.ldq_head), 1);
    chk("t5_tail", 32'(dut.ldq_tail), 1);
    chk("t5_ldqid", 32'(bus.ldqid_alloc_rs0), 1);

    // 6: retire + drain + store same cycle: all three advance
    do_reset();
    for (int i = 0; i < 2; i++) begin st(); tick(); idle(); end
    bus.stq_retire = 1'b1;
    tick(); idle();
    st(); bus.stq_retire = 1'b1; bus.stq_drain = 1'b1;
    tick(); idle(); #1;
    chk("t6_head", 32'(dut.stq_head), 1);
    chk("t6_cmt", 32'(dut.stq_cmt), 2);
    chk("t6_tail", 32'(dut.stq_tail), 3);
    chk("t6_stqid", 32'(bus.stqid_alloc_rs0), 3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
